// File: rtl/apb_uart_tx_ctrl.sv
// APB-slave UART transmitter: CTRL/DIV/STATUS registers, TX FIFO and frame serialiser
// sharing one clock domain; zero-wait-state slave with error response on unmapped addresses.
module apb_uart_tx_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int FIFO_DEPTH  = 16,
  parameter int DATA_BITS   = 8,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 433
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              uart_tx_o,
  output logic              tx_busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // APB decode
  logic       w_access, w_addr_ok, w_wr, w_rd;
  logic [1:0] w_sel;
  logic       w_unused;

  assign w_access  = psel & penable;
  assign w_addr_ok = (paddr[ADDR_W-1:4] == '0);
  assign w_wr      = w_access & pwrite & w_addr_ok;
  assign w_rd      = w_access & ~pwrite & w_addr_ok;
  assign w_sel     = paddr[3:2];
  assign pready    = 1'b1;
  assign pslverr   = w_access & ~w_addr_ok;
  assign w_unused  = ^{pwdata, paddr[1:0]};

  // Registers
  logic [3:0]       r_ctrl;
  logic [DIV_W-1:0] r_div;
  logic             r_ovf;

  // FIFO
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [LW-1:0]        r_level;
  logic                 w_full, w_empty, w_push_req, w_push, w_pop;

  assign w_full     = (r_level == LW'(FIFO_DEPTH));
  assign w_empty    = (r_level == '0);
  assign w_push_req = w_wr && (w_sel == 2'd0);
  assign w_push     = w_push_req && !w_full;

  // Serialiser state and per-frame copies of the configuration
  state_t               r_state, w_state_nxt;
  logic [DIV_W-1:0]     r_cnt, r_f_div;
  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]           r_bit_idx;
  logic                 r_stop_idx, r_f_par_en, r_f_par_bit, r_f_two_stop;
  logic                 r_tx;
  logic                 w_tick, w_can_pop, w_tx_nxt;

  assign w_tick    = (r_cnt == '0);
  assign w_can_pop = r_ctrl[0] && !w_empty;
  assign uart_tx_o = r_tx;
  assign tx_busy_o = (r_state != S_IDLE);

  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (preset) begin
      r_ctrl <= '0;
      r_div  <= DIV_W'(DEFAULT_DIV);
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr && (w_sel == 2'd1)) r_ctrl <= pwdata[3:0];
      if (w_wr && (w_sel == 2'd2)) r_div  <= pwdata[DIV_W-1:0];
      // A dropped push reports overflow even when a pop frees a slot in the same cycle
      if (w_push_req && w_full)                         r_ovf <= 1'b1;
      else if (w_wr && (w_sel == 2'd3) && pwdata[3])    r_ovf <= 1'b0;
    end
  end

  // NOTE: storage array is not reset; flushing the pointers is enough to make it empty.
  always_ff @(posedge pclk) begin
    if (w_push) r_mem[r_wptr] <= pwdata[DATA_BITS-1:0];
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_can_pop) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START:  if (w_tick) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_tick && (r_bit_idx == 3'(DATA_BITS - 1)))
          w_state_nxt = r_f_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: if (w_tick) w_state_nxt = S_STOP;
      S_STOP: begin
        if (w_tick && (!r_f_two_stop || r_stop_idx)) begin
          if (w_can_pop) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_tx_nxt = 1'b1;
    case (r_state)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = r_shift[0];
      S_PARITY: w_tx_nxt = r_f_par_bit;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_tx         <= 1'b1;
      r_cnt        <= '0;
      r_f_div      <= '0;
      r_shift      <= '0;
      r_bit_idx    <= '0;
      r_stop_idx   <= 1'b0;
      r_f_par_en   <= 1'b0;
      r_f_par_bit  <= 1'b0;
      r_f_two_stop <= 1'b0;
    end else begin
      r_tx <= w_tx_nxt;
      if (w_pop) begin
        // Odd parity (CTRL[2]=1) is the inverse of the data XOR
        r_shift      <= r_mem[r_rptr];
        r_f_par_en   <= ^r_ctrl[2:1];
        r_f_par_bit  <= (^r_mem[r_rptr]) ^ r_ctrl[2];
        r_f_two_stop <= r_ctrl[3];
        r_f_div      <= r_div;
        r_cnt        <= r_div;
        r_bit_idx    <= '0;
        r_stop_idx   <= 1'b0;
      end else if (r_state != S_IDLE) begin
        if (w_tick) begin
          r_cnt <= r_f_div;
          if (r_state == S_DATA) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + 3'd1;
          end
          if (r_state == S_STOP) r_stop_idx <= 1'b1;
        end else begin
          r_cnt <= r_cnt - DIV_W'(1);
        end
      end
    end
  end

  always_comb begin
    prdata = '0;
    if (w_rd) begin
      case (w_sel)
        2'd1:    prdata = {28'd0, r_ctrl};
        2'd2:    prdata = 32'(r_div);
        2'd3:    prdata = {16'd0, 8'(r_level), 4'd0, r_ovf, tx_busy_o, w_full, w_empty};
        default: prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_tx_ctrl.sv
// Directed bench for apb_uart_tx_ctrl: register access, frame timing, parity/stop options,
// FIFO overflow with back-to-back drain, APB error response and mid-frame reset.
module tb_apb_uart_tx_ctrl;

  logic        pclk = 1'b0;
  logic        preset, psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, uart_tx_o, tx_busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  apb_uart_tx_ctrl #(
    .ADDR_W(12), .FIFO_DEPTH(16), .DATA_BITS(8), .DIV_W(16), .DEFAULT_DIV(433)
  ) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .uart_tx_o(uart_tx_o), .tx_busy_o(tx_busy_o)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    #1 err = pslverr;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic e;
    apb_write(a, d, e);
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    #1 d = prdata; err = pslverr;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  // Observes one frame starting at the cycle the start bit appears; vec holds line bits in send order.
  task automatic capture_frame(input logic [15:0] vec, input int nbits, input int div,
                               output int bad_tx, output int busy_low);
    bad_tx = 0; busy_low = 0;
    for (int j = 0; j < nbits * (div + 1); j++) begin
      @(negedge pclk);
      if (uart_tx_o !== vec[j / (div + 1)]) bad_tx++;
      if (tx_busy_o !== 1'b1) busy_low++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e;
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(negedge pclk);
    n_cmp++; if (uart_tx_o !== 1'b1) begin n_bad++; $display("FAIL t1_line: got %b want 1", uart_tx_o); end
    n_cmp++; if (tx_busy_o !== 1'b0) begin n_bad++; $display("FAIL t1_busy: got %b want 0", tx_busy_o); end
    preset = 1'b0;
    apb_read(12'hC, d, e);
    n_cmp++; if (d !== 32'h0000_0001) begin n_bad++; $display("FAIL t1_status: got %h want 00000001", d); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL t1_status_err: got %b want 0", e); end
    apb_read(12'h8, d, e);
    n_cmp++; if (d !== 32'd433) begin n_bad++; $display("FAIL t1_div: got %0d want 433", d); end
    apb_read(12'h4, d, e);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL t1_ctrl: got %h want 0", d); end
    apb_read(12'h0, d, e);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL t1_txdata_rd: got %h want 0", d); end
  endtask

  task automatic test_basic_frame();
    int bad, bl;
    wr(12'h8, 32'd3);
    wr(12'h4, 32'h1);
    wr(12'h0, 32'hA5);
    @(negedge pclk);
    n_cmp++; if (uart_tx_o !== 1'b1) begin n_bad++; $display("FAIL t2_pop_line: got %b want 1", uart_tx_o); end
    n_cmp++; if (tx_busy_o !== 1'b1) begin n_bad++; $display("FAIL t2_pop_busy: got %b want 1", tx_busy_o); end
    capture_frame(16'h034A, 10, 3, bad, bl);
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL t2_line_bad_cycles: got %0d want 0", bad); end
    n_cmp++; if (bl !== 1) begin n_bad++; $display("FAIL t2_busy_low_cycles: got %0d want 1", bl); end
    @(negedge pclk);
    n_cmp++; if (uart_tx_o !== 1'b1) begin n_bad++; $display("FAIL t2_idle_line: got %b want 1", uart_tx_o); end
    n_cmp++; if (tx_busy_o !== 1'b0) begin n_bad++; $display("FAIL t2_idle_busy: got %b want 0", tx_busy_o); end
  endtask

  task automatic test_parity_stop();
    logic [31:0] ctrl [3] = '{32'h3, 32'h5, 32'h9};
    logic [15:0] vec  [3] = '{16'h060E, 16'h040E, 16'h060E};
    int bad, bl;
    for (int c = 0; c < 3; c++) begin
      wr(12'h4, ctrl[c]);
      wr(12'h0, 32'h07);
      @(negedge pclk);
      n_cmp++; if (tx_busy_o !== 1'b1) begin n_bad++; $display("FAIL t3_pop_busy[%0d]: got %b want 1", c, tx_busy_o); end
      capture_frame(vec[c], 11, 3, bad, bl);
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL t3_line_bad_cycles[%0d]: got %0d want 0", c, bad); end
      n_cmp++; if (bl !== 1) begin n_bad++; $display("FAIL t3_busy_low_cycles[%0d]: got %0d want 1", c, bl); end
      @(negedge pclk);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e;
    logic [7:0] w;
    int bad, bl;
    wr(12'h4, 32'h0);
    for (int i = 0; i < 17; i++) wr(12'h0, 32'h30 + i);
    apb_read(12'hC, d, e);
    n_cmp++; if (d !== 32'h0000_100A) begin n_bad++; $display("FAIL t4_status_full: got %h want 0000100a", d); end
    wr(12'hC, 32'h8);
    apb_read(12'hC, d, e);
    n_cmp++; if (d !== 32'h0000_1002) begin n_bad++; $display("FAIL t4_status_ovf_clr: got %h want 00001002", d); end
    wr(12'h4, 32'h1);
    @(negedge pclk);
    n_cmp++; if (tx_busy_o !== 1'b1) begin n_bad++; $display("FAIL t4_pop_busy: got %b want 1", tx_busy_o); end
    for (int f = 0; f < 16; f++) begin
      w = 8'h30 + 8'(f);
      capture_frame({6'b0, 1'b1, w, 1'b0}, 10, 3, bad, bl);
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL t4_frame%0d_line: got %0d bad cycles want 0", f, bad); end
      n_cmp++; if (bl !== ((f == 15) ? 1 : 0)) begin n_bad++; $display("FAIL t4_frame%0d_busy_low: got %0d want %0d", f, bl, (f == 15) ? 1 : 0); end
    end
    apb_read(12'hC, d, e);
    n_cmp++; if (d !== 32'h0000_0001) begin n_bad++; $display("FAIL t4_status_drained: got %h want 00000001", d); end
  endtask

  task automatic test_slverr();
    logic [31:0] d; logic e;
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'hFFFF_FFFF; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    n_cmp++; if (pslverr !== 1'b1) begin n_bad++; $display("FAIL t5_wr_err: got %b want 1", pslverr); end
    n_cmp++; if (pready !== 1'b1) begin n_bad++; $display("FAIL t5_pready: got %b want 1", pready); end
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    apb_write(12'h014, 32'h0, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL t5_wr14_err: got %b want 1", e); end
    apb_read(12'h010, d, e);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL t5_rd_data: got %h want 0", d); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL t5_rd_err: got %b want 1", e); end
    apb_read(12'h8, d, e);
    n_cmp++; if (d !== 32'd3) begin n_bad++; $display("FAIL t5_div_kept: got %0d want 3", d); end
    apb_read(12'h4, d, e);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL t5_ctrl_kept: got %h want 1", d); end
    apb_read(12'hC, d, e);
    n_cmp++; if (d !== 32'h0000_0001) begin n_bad++; $display("FAIL t5_status_kept: got %h want 00000001", d); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d; logic e;
    wr(12'h4, 32'h0);
    wr(12'h0, 32'h11);
    wr(12'h0, 32'h22);
    wr(12'h0, 32'h33);
    wr(12'h4, 32'h1);
    repeat (19) @(negedge pclk);
    n_cmp++; if (tx_busy_o !== 1'b1) begin n_bad++; $display("FAIL t6_busy_before: got %b want 1", tx_busy_o); end
    preset = 1'b1;
    @(negedge pclk);
    n_cmp++; if (uart_tx_o !== 1'b1) begin n_bad++; $display("FAIL t6_line_after_rst: got %b want 1", uart_tx_o); end
    n_cmp++; if (tx_busy_o !== 1'b0) begin n_bad++; $display("FAIL t6_busy_after_rst: got %b want 0", tx_busy_o); end
    preset = 1'b0;
    apb_read(12'hC, d, e);
    n_cmp++; if (d !== 32'h0000_0001) begin n_bad++; $display("FAIL t6_status: got %h want 00000001", d); end
    apb_read(12'h8, d, e);
    n_cmp++; if (d !== 32'd433) begin n_bad++; $display("FAIL t6_div: got %0d want 433", d); end
    repeat (8) @(negedge pclk);
    n_cmp++; if (uart_tx_o !== 1'b1) begin n_bad++; $display("FAIL t6_line_idle: got %b want 1", uart_tx_o); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity_stop();
    test_back_to_back();
    test_slverr();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
